// File: rtl/sprite_update_scheduler_pkg.sv
// Shared scheduler types and the sprite index map used by the game master FSM.
package game_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

  localparam int SPR_TARGET_1  = 0;
  localparam int SPR_TARGET_2  = 1;
  localparam int SPR_TARGET_3  = 2;
  localparam int SPR_BULLET    = 3;
  localparam int SPR_SPACESHIP = 4;
  localparam int SPR_HEART_1   = 5;
  localparam int SPR_HEART_2   = 6;
  localparam int SPR_HEART_3   = 7;

endpackage

// File: rtl/sprite_update_scheduler_rate_divider.sv
// Per-sprite frame rate divider: a sprite is due when its down-counter reads zero.
module sprite_rate_divider #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             reload,
  input  logic             dec,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             expired
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;

  // Divider register; writes never disturb the running count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div <= '0;
    else if (cfg_we) div <= cfg_div;
  end

  // Down-counter: cleared while the sprite is stopped so it moves on its first frame back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (reload)              cnt <= div;
    else if (dec && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sprite_update_scheduler.sv
// Per-frame walker over all sprites, issuing one motion update per due sprite.
module sprite_update_scheduler
  import game_sched_pkg::*;
#(
  parameter  int N_SPRITES = 8,
  parameter  int DIV_W     = 4,
  localparam int IDX_W     = $clog2(N_SPRITES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 pause,
  input  logic [N_SPRITES-1:0] run_mask,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [DIV_W-1:0]     cfg_div,
  output logic                 upd_valid,
  output logic [IDX_W-1:0]     upd_idx,
  input  logic                 upd_ready,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic [15:0]          frame_cnt
);

  sched_state_t         state;
  logic [IDX_W-1:0]     ptr;
  logic [N_SPRITES-1:0] expired;
  logic                 issue_now;
  logic                 last;

  assign issue_now = run_mask[ptr] & expired[ptr];
  assign last      = (ptr == IDX_W'(N_SPRITES - 1));

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_div
    logic sel;
    assign sel = (state == SCAN) && (ptr == IDX_W'(i));

    sprite_rate_divider #(.DIV_W(DIV_W)) u_div (
      .clk     (clk),
      .rst     (rst),
      .clr     (sel & ~run_mask[i]),
      .reload  (sel & run_mask[i] & expired[i]),
      .dec     (sel & run_mask[i] & ~expired[i]),
      .cfg_we  (cfg_we && (cfg_idx == IDX_W'(i))),
      .cfg_div (cfg_div),
      .expired (expired[i])
    );
  end

  // Sequencer: frame accept, one sprite per SCAN cycle, hold request through ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start && !pause) begin
            state     <= SCAN;
            ptr       <= '0;
            busy      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        SCAN: begin
          if (issue_now) begin
            upd_valid <= 1'b1;
            upd_idx   <= ptr;
            state     <= ISSUE;
          end else if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ISSUE: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            if (last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= SCAN;
            end
          end
        end
        default: begin
          state     <= IDLE;
          upd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a frame tick landing mid-scan is dropped; setting beats clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overrun <= 1'b0;
    else if (frame_start && busy)  overrun <= 1'b1;
    else if (overrun_clr)          overrun <= 1'b0;
  end

endmodule

// File: tb/tb_sprite_update_scheduler.sv
// Bench for sprite_update_scheduler: directed scenarios plus random traffic vs. a frame-level model.
module tb_sprite_update_scheduler;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] run_mask = 8'h00;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = 3'd0;
  logic [3:0] cfg_div = 4'd0;
  logic       upd_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       upd_valid;
  logic [2:0] upd_idx;
  logic       busy;
  logic       overrun;
  logic [15:0] frame_cnt;

  sprite_update_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pause(pause),
    .run_mask(run_mask), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_div(cfg_div),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ready(upd_ready),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;
  int tr_log[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A frame is a walk over sprites 0..7; each visited sprite either ticks its
  // frame counter or, when due, becomes an outstanding request that blocks the walk.
  int  m_cnt[N];
  int  m_div[N];
  bit  m_busy, m_req, m_over;
  int  m_pos, m_idx, m_frames;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_div[i] = 0; end
    m_busy = 0; m_req = 0; m_over = 0; m_pos = 0; m_idx = 0; m_frames = 0;
  endfunction

  function automatic void model_next_sprite();
    if (m_pos == N - 1) m_busy = 0;
    else m_pos = m_pos + 1;
  endfunction

  function automatic void model_step();
    if (frame_start && m_busy) m_over = 1;
    else if (overrun_clr) m_over = 0;
    if (!m_busy) begin
      if (frame_start && !pause) begin
        m_busy = 1; m_pos = 0; m_frames = (m_frames + 1) % 65536;
      end
    end else if (m_req) begin
      if (upd_ready) begin m_req = 0; model_next_sprite(); end
    end else if (!run_mask[m_pos]) begin
      m_cnt[m_pos] = 0; model_next_sprite();
    end else if (m_cnt[m_pos] > 0) begin
      m_cnt[m_pos] = m_cnt[m_pos] - 1; model_next_sprite();
    end else begin
      m_cnt[m_pos] = m_div[m_pos]; m_req = 1; m_idx = m_pos;
    end
    if (cfg_we) m_div[cfg_idx] = int'(cfg_div);
  endfunction

  // Model advances on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Transfer log of what the design actually handed to the datapath.
  always @(posedge clk) begin
    if (!rst && upd_valid && upd_ready) tr_log.push_back(int'(upd_idx));
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("upd_valid", int'(upd_valid), int'(m_req));
      if (m_req) chk("upd_idx", int'(upd_idx), m_idx);
      chk("busy", int'(busy), int'(m_busy));
      chk("overrun", int'(overrun), int'(m_over));
      chk("frame_cnt", int'(frame_cnt), m_frames);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers (all called at a negedge) ----------------
  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 500) begin @(negedge clk); k++; end
    chk(name, int'(busy), 0);
  endtask

  task automatic write_div(input int idx, input int val);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_div = 4'(val);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  int n0;
  int exp_t2[6];
  int exp_t4[3];

  initial begin
    exp_t2 = '{1, 0, 0, 1, 0, 0};
    exp_t4 = '{0, 0, 1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    // reset state
    chk("rst_valid", int'(upd_valid), 0);
    chk("rst_idx", int'(upd_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);

    // 1: every sprite, every frame
    run_mask = 8'hFF; upd_ready = 1'b1;
    tr_log.delete();
    pulse_frame();
    chk("t1_lat_cycle1", int'(upd_valid), 0);
    @(negedge clk);
    chk("t1_lat_cycle2", int'(upd_valid), 1);
    chk("t1_first_idx", int'(upd_idx), 0);
    wait_idle("t1_idle");
    chk("t1_count", tr_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < tr_log.size()) chk("t1_order", tr_log[i], i);
    chk("t1_frame_cnt", int'(frame_cnt), 1);

    // 2: divider of 2 on sprite 2 only
    run_mask = 8'h04;
    write_div(2, 2);
    for (int f = 0; f < 6; f++) begin
      n0 = tr_log.size();
      pulse_frame();
      wait_idle("t2_idle");
      chk("t2_frame_updates", tr_log.size() - n0, exp_t2[f]);
      if (tr_log.size() > n0) chk("t2_idx", tr_log[n0], 2);
    end
    chk("t2_frame_cnt", int'(frame_cnt), 7);

    // 4: paused frame freezes counters and frame count
    n0 = tr_log.size();
    pulse_frame(); wait_idle("t4_idle_a");
    chk("t4_f7_update", tr_log.size() - n0, 1);
    n0 = tr_log.size();
    pause = 1'b1; pulse_frame(); pause = 1'b0;
    chk("t4_pause_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    chk("t4_pause_updates", tr_log.size() - n0, 0);
    chk("t4_pause_frame_cnt", int'(frame_cnt), 8);
    for (int f = 0; f < 3; f++) begin
      n0 = tr_log.size();
      pulse_frame(); wait_idle("t4_idle_b");
      chk("t4_after_pause", tr_log.size() - n0, exp_t4[f]);
    end

    // 3: back-pressure holds request 0, then sprite 7
    run_mask = 8'h81; upd_ready = 1'b0;
    n0 = tr_log.size();
    pulse_frame();
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", int'(upd_valid), 1);
      chk("t3_hold_idx", int'(upd_idx), 0);
      @(negedge clk);
    end
    upd_ready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_count", tr_log.size() - n0, 2);
    if (tr_log.size() - n0 == 2) begin
      chk("t3_first", tr_log[n0], 0);
      chk("t3_second", tr_log[n0 + 1], 7);
    end

    // 5: overrun while stalled, set beats clear
    run_mask = 8'h01; upd_ready = 1'b0;
    n0 = tr_log.size();
    pulse_frame();
    @(negedge clk);
    chk("t5_no_overrun", int'(overrun), 0);
    pulse_frame();
    chk("t5_overrun_set", int'(overrun), 1);
    chk("t5_frame_cnt", int'(frame_cnt), 13);
    frame_start = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; overrun_clr = 1'b0;
    chk("t5_set_wins", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("t5_cleared", int'(overrun), 0);
    upd_ready = 1'b1;
    wait_idle("t5_idle");
    repeat (3) @(negedge clk);
    chk("t5_one_scan", tr_log.size() - n0, 1);
    chk("t5_frame_cnt_end", int'(frame_cnt), 13);

    // 6: async reset abandons a stalled request
    run_mask = 8'hFF;
    write_div(0, 0);
    for (int i = 1; i < 8; i++) write_div(i, 3);
    pulse_frame(); wait_idle("t6_idle_a");
    pulse_frame(); wait_idle("t6_idle_b");
    upd_ready = 1'b0;
    pulse_frame();
    @(negedge clk);
    chk("t6_stalled", int'(upd_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(upd_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    upd_ready = 1'b1;
    n0 = tr_log.size();
    pulse_frame(); wait_idle("t6_idle_c");
    chk("t6_all_update", tr_log.size() - n0, 8);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      frame_start = ($urandom_range(0, 9) == 0);
      pause       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) run_mask = 8'($urandom);
      upd_ready   = ($urandom_range(0, 9) < 7);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_idx     = 3'($urandom_range(0, 7));
      cfg_div     = 4'($urandom_range(0, 3));
      overrun_clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    frame_start = 1'b0; cfg_we = 1'b0; overrun_clr = 1'b0; upd_ready = 1'b1;
    wait_idle("rand_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
